// File: rtl/timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and byte-strobe merge helper
// for the iomem timer/PWM peripheral.
package timer_pkg;

  // Word offsets, compared against iomem_addr[7:2]
  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_PRESC  = 6'h01;
  localparam logic [5:0] OFF_COUNT  = 6'h02;
  localparam logic [5:0] OFF_CMP    = 6'h03;
  localparam logic [5:0] OFF_STATUS = 6'h04;
  localparam logic [5:0] OFF_DUTY   = 6'h05;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_AR      = 1;
  localparam int CTRL_IE      = 2;
  localparam int STATUS_MATCH = 0;

  function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = strb[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: free-runs while enabled and emits one tick every PRESC+1 cycles.
module timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] presc,
  output logic        tick
);

  logic [31:0] pcnt;

  assign tick = en && (pcnt == presc);

  always_ff @(posedge clk) begin
    if (reset)     pcnt <= '0;
    else if (clr)  pcnt <= '0;
    else if (en)   pcnt <= tick ? '0 : pcnt + 32'd1;
  end

endmodule

// File: rtl/iomem_timer.sv
// Timer/PWM peripheral on the iomem bus: one-wait-state register access,
// prescaled compare counter with one-shot/auto-reload, PWM and level irq.
module iomem_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq,
  output logic        pwm_out
);

  logic        sel, acc, wr;
  logic [5:0]  off;
  logic [2:0]  ctrl, ctrl_nxt;
  logic [31:0] presc, count, cmp, duty, rmux;
  logic        match, tick, clr, is_match;
  logic        wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status, wr_duty;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = &{1'b0, iomem_addr[1:0]};

  assign sel = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign acc = sel && !iomem_ready;
  assign wr  = acc && (|iomem_wstrb);
  assign off = iomem_addr[7:2];

  assign wr_ctrl   = wr && (off == OFF_CTRL);
  assign wr_presc  = wr && (off == OFF_PRESC);
  assign wr_count  = wr && (off == OFF_COUNT);
  assign wr_cmp    = wr && (off == OFF_CMP);
  assign wr_status = wr && (off == OFF_STATUS);
  assign wr_duty   = wr && (off == OFF_DUTY);

  assign ctrl_nxt = iomem_wstrb[0] ? iomem_wdata[2:0] : ctrl;
  // Restart the prescaler phase whenever the timer is freshly enabled
  assign clr      = wr_ctrl && !ctrl[CTRL_EN] && ctrl_nxt[CTRL_EN];
  assign is_match = (count == cmp);
  assign irq      = match && ctrl[CTRL_IE];

  timer_prescaler u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl[CTRL_EN]),
    .clr   (clr),
    .presc (presc),
    .tick  (tick)
  );

  always_comb begin
    rmux = '0;
    case (off)
      OFF_CTRL:   rmux = {29'b0, ctrl};
      OFF_PRESC:  rmux = presc;
      OFF_COUNT:  rmux = count;
      OFF_CMP:    rmux = cmp;
      OFF_STATUS: rmux = {31'b0, match};
      OFF_DUTY:   rmux = duty;
      default:    rmux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      ctrl        <= '0;
      presc       <= '0;
      count       <= '0;
      cmp         <= '0;
      match       <= 1'b0;
      duty        <= '0;
      pwm_out     <= 1'b0;
    end else begin
      iomem_ready <= acc;
      iomem_rdata <= (acc && !(|iomem_wstrb)) ? rmux : '0;

      // Ordering matters: W1C before the tick so a same-cycle match wins,
      // tick before bus writes so COUNT/CTRL writes win over the tick.
      if (wr_status && iomem_wstrb[0] && iomem_wdata[STATUS_MATCH])
        match <= 1'b0;

      if (tick) begin
        if (is_match) begin
          count <= '0;
          match <= 1'b1;
          if (!ctrl[CTRL_AR]) ctrl[CTRL_EN] <= 1'b0;
        end else begin
          count <= count + 32'd1;
        end
      end

      if (wr_ctrl)  ctrl  <= ctrl_nxt;
      if (wr_presc) presc <= apply_strb(presc, iomem_wdata, iomem_wstrb);
      if (wr_count) count <= apply_strb(count, iomem_wdata, iomem_wstrb);
      if (wr_cmp)   cmp   <= apply_strb(cmp,   iomem_wdata, iomem_wstrb);
      if (wr_duty)  duty  <= apply_strb(duty,  iomem_wdata, iomem_wstrb);

      pwm_out <= ctrl[CTRL_EN] && (count < duty);
    end
  end

endmodule

// File: tb/tb_iomem_timer.sv
// Scoreboarded bench for iomem_timer: bus tasks queue the expected rdata,
// a negedge monitor pops and compares on every iomem_ready.
module tb_iomem_timer;
  import timer_pkg::*;

  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        irq;
  logic        pwm_out;

  int errors = 0;
  int checks = 0;
  int last_lat = 0;
  logic [31:0] exp_q[$];

  iomem_timer #(.BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .irq         (irq),
    .pwm_out     (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completion must match the oldest queued expectation
  always @(negedge clk) begin
    if (iomem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready with empty queue, expected none");
      end else begin
        chk("rdata", iomem_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wd, input logic [31:0] exp_rd);
    int n;
    exp_q.push_back(exp_rd);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = wd;
    n = 0;
    do begin
      step();
      n++;
    end while (iomem_ready !== 1'b1 && n < 10);
    if (iomem_ready !== 1'b1) begin
      chk("ready_timeout", 32'(iomem_ready), 32'd1);
      void'(exp_q.pop_back());
    end
    last_lat    = n;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  function automatic logic [31:0] ra(input logic [5:0] off);
    return BASE + {24'b0, off, 2'b00};
  endfunction

  task automatic wr(input logic [5:0] off, input logic [31:0] d);
    bus(ra(off), 4'hF, d, 32'h0);
  endtask

  task automatic rd(input logic [5:0] off, input logic [31:0] e);
    bus(ra(off), 4'h0, 32'h0, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [31:0] exp_pwm;
    reset       = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = '0;
    iomem_wdata = '0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    chk("rst_ready", 32'(iomem_ready), 0);
    chk("rst_rdata", iomem_rdata, 0);
    chk("rst_irq",   32'(irq), 0);
    chk("rst_pwm",   32'(pwm_out), 0);
    rd(OFF_CTRL, 0);
    chk("ready_latency", last_lat, 1);
    step();
    chk("ready_one_cycle", 32'(iomem_ready), 0);
    rd(OFF_PRESC, 0);
    rd(OFF_COUNT, 0);
    rd(OFF_CMP, 0);
    rd(OFF_STATUS, 0);
    rd(OFF_DUTY, 0);

    // Auto-reload, PRESC=0, CMP=3: COUNT 1,2,3,0..., MATCH set on 4th tick
    wr(OFF_PRESC, 0);
    wr(OFF_CMP, 3);
    wr(OFF_CTRL, 32'h7);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("ar_irq_rise", 32'(irq), (k == 4) ? 1 : 0);
    end
    rd(OFF_COUNT, 0);
    rd(OFF_COUNT, 2);
    chk("ar_irq_high", 32'(irq), 1);
    wr(OFF_STATUS, 1);
    chk("w1c_irq_low", 32'(irq), 0);
    wr(OFF_CTRL, 0);
    rd(OFF_STATUS, 0);
    wr(OFF_COUNT, 0);

    // One-shot, PRESC=2, CMP=1
    wr(OFF_PRESC, 2);
    wr(OFF_CMP, 1);
    wr(OFF_CTRL, 32'h5);
    repeat (3) step();
    rd(OFF_COUNT, 1);
    step();
    chk("os_irq_pre", 32'(irq), 0);
    step();
    chk("os_irq_set", 32'(irq), 1);
    repeat (10) step();
    rd(OFF_COUNT, 0);
    rd(OFF_CTRL, 32'h4);
    rd(OFF_STATUS, 1);
    wr(OFF_STATUS, 1);
    wr(OFF_CTRL, 0);
    rd(OFF_STATUS, 0);

    // PWM: CMP=9, DUTY=3 -> high 3 of every 10 cycles
    wr(OFF_PRESC, 0);
    wr(OFF_CMP, 9);
    wr(OFF_DUTY, 3);
    wr(OFF_COUNT, 0);
    wr(OFF_CTRL, 32'h3);
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_pwm = (((k - 1) % 10) < 3) ? 1 : 0;
      chk("pwm_wave", 32'(pwm_out), exp_pwm);
      seen += int'(pwm_out);
    end
    chk("pwm_high_count", seen, 6);
    wr(OFF_DUTY, 0);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("pwm_duty0", 32'(pwm_out), 0);
    end
    wr(OFF_CTRL, 0);

    // Collision: COUNT write lands on a tick edge (PRESC=1)
    wr(OFF_PRESC, 1);
    wr(OFF_CMP, 32'h1000);
    wr(OFF_COUNT, 0);
    wr(OFF_CTRL, 32'h3);
    wr(OFF_COUNT, 32'h100);
    rd(OFF_COUNT, 32'h100);
    wr(OFF_CTRL, 0);

    // Collision: W1C lands on the one-shot match edge
    wr(OFF_STATUS, 1);
    wr(OFF_CMP, 0);
    wr(OFF_COUNT, 0);
    wr(OFF_CTRL, 32'h1);
    wr(OFF_STATUS, 1);
    rd(OFF_STATUS, 1);
    rd(OFF_CTRL, 0);
    wr(OFF_STATUS, 1);
    rd(OFF_STATUS, 0);

    // Byte strobes and decode
    bus(ra(OFF_CMP), 4'b0010, 32'hAABB_CCDD, 0);
    rd(OFF_CMP, 32'h0000_CC00);
    wr(OFF_PRESC, 32'h1122_3344);
    bus(ra(OFF_PRESC), 4'b1000, 32'hAA00_0000, 0);
    rd(OFF_PRESC, 32'hAA22_3344);
    wr(OFF_CTRL, 32'hFFFF_FFF0);
    rd(OFF_CTRL, 0);
    wr(6'h10, 32'hDEAD_BEEF);
    rd(6'h10, 0);

    iomem_valid = 1'b1;
    iomem_addr  = 32'h0400_0000;
    iomem_wstrb = 4'h0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      seen += int'(iomem_ready);
    end
    iomem_valid = 1'b0;
    chk("out_of_window_ready", seen, 0);

    // Reset in mid-transfer drops the write
    step();
    iomem_valid = 1'b1;
    iomem_addr  = ra(OFF_CMP);
    iomem_wstrb = 4'hF;
    iomem_wdata = 32'h55;
    reset       = 1'b1;
    step();
    chk("rst_mid_ready", 32'(iomem_ready), 0);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    reset       = 1'b0;
    step();
    rd(OFF_CMP, 0);

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
